// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the eight-digit common-anode scanner.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {G,F,E,D,C,B,A}, entry 15 first so that HEX_SEG[n] decodes nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  dp;
  } disp_word_t;

endpackage

// File: rtl/hex7_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module hex7_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed display driver: load port, pending/active word, slot/digit counters
// and a registered output stage so anode and segments always switch on the same edge.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_en,
  input  logic [7:0]  load_dp,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_tick
);

  localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [SLOT_W-1:0] r_slot;
  logic [2:0]        r_digit;
  disp_word_t        r_act;
  disp_word_t        r_pend;
  logic              r_pend_full;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [7:0]        r_an;
  logic              r_frame_tick;

  logic              w_slot_wrap;
  logic              w_frame_wrap;
  logic              w_pre_wrap;
  logic              w_blank;
  logic [3:0]        w_nibble;
  logic [6:0]        w_seg;

  assign w_slot_wrap  = (r_slot == SLOT_W'(DIV - 1));
  assign w_frame_wrap = w_slot_wrap && (r_digit == 3'd7);
  assign w_pre_wrap   = (r_slot == SLOT_W'(DIV - 2)) && (r_digit == 3'd7);
  assign w_blank      = (r_slot < SLOT_W'(GUARD)) || !r_act.en[r_digit];
  assign w_nibble     = r_act.data[{r_digit, 2'b00} +: 4];

  hex7_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_digit <= '0;
    end else if (w_slot_wrap) begin
      r_slot  <= '0;
      r_digit <= r_digit + 3'd1;
    end else begin
      r_slot  <= r_slot + SLOT_W'(1);
    end
  end

  // Pending word is only replaced while empty, so a commit and a transfer never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else if (r_pend_full) begin
      if (w_frame_wrap) begin
        r_act       <= r_pend;
        r_pend_full <= 1'b0;
      end
    end else if (load_valid) begin
      r_pend      <= '{data: load_data, en: load_en, dp: load_dp};
      r_pend_full <= 1'b1;
    end
  end

  // frame_tick is set one edge early so that it is high exactly during the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_pre_wrap;
      if (w_blank) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(8'b1 << r_digit);
        r_seg <= w_seg;
        r_dp  <= ~r_act.dp[r_digit];
      end
    end
  end

  assign load_ready = ~r_pend_full;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with DIV=4, GUARD=1 against a cycle-count model.
module tb_seven_seg_scanner;

  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic [7:0]  load_en = '0;
  logic [7:0]  load_dp = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_tick;

  seven_seg_scanner #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_en    (load_en),
    .load_dp    (load_dp),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: absolute cycle count since reset plus the two words.
  int          m_k;
  logic [31:0] m_act_data, m_pend_data;
  logic [7:0]  m_act_en, m_pend_en, m_act_dp, m_pend_dp;
  bit          m_pend_full;
  logic [7:0]  m_last_an;
  int          tick_cnt;
  int          lit_cnt [8];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_reset();
    m_k = 0;
    m_act_data = '0; m_act_en = '0; m_act_dp = '0;
    m_pend_data = '0; m_pend_en = '0; m_pend_dp = '0;
    m_pend_full = 0;
    m_last_an = 8'hFF;
  endtask

  task automatic fail_msg(input string name, input int act, input int exp);
    errors++;
    if (errors <= 40)
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m_k, act, exp);
  endtask

  // One clock edge: predict, advance, then compare every output.
  task automatic step();
    int         slot, dig, ones;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    bit         xfer, commit;
    slot = m_k % DIV;
    dig  = (m_k / DIV) % 8;
    if (slot < GUARD || !m_act_en[dig]) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = 8'hFF;
      e_an[dig] = 1'b0;
      e_seg = seg_tab[(m_act_data >> (4 * dig)) & 32'hF];
      e_dp  = ~m_act_dp[dig];
    end
    xfer   = load_valid && !m_pend_full;
    commit = m_pend_full && ((m_k % FRAME) == FRAME - 1);
    @(posedge clk);
    if (commit) begin
      m_act_data = m_pend_data; m_act_en = m_pend_en; m_act_dp = m_pend_dp;
      m_pend_full = 0;
    end else if (xfer) begin
      m_pend_data = load_data; m_pend_en = load_en; m_pend_dp = load_dp;
      m_pend_full = 1;
    end
    m_k++;
    m_last_an = e_an;
    #1;
    checks++;
    if (an !== e_an) fail_msg("an", an, e_an);
    checks++;
    if (seg !== e_seg) fail_msg("seg", seg, e_seg);
    checks++;
    if (dp !== e_dp) fail_msg("dp", dp, e_dp);
    checks++;
    if (frame_tick !== ((m_k % FRAME) == FRAME - 1)) fail_msg("frame_tick", frame_tick, (m_k % FRAME) == FRAME - 1);
    checks++;
    if (load_ready !== !m_pend_full) fail_msg("load_ready", load_ready, !m_pend_full);
    ones = $countones(~an);
    checks++;
    if (ones > 1) fail_msg("anode_onehot", ones, 1);
    if (frame_tick === 1'b1) tick_cnt++;
    for (int d = 0; d < 8; d++) if (an === ~(8'b1 << d)) lit_cnt[d]++;
  endtask

  // Present a word and hold it until the model sees it accepted (bounded).
  task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    bit done = 0;
    load_valid = 1'b1; load_data = d; load_en = e; load_dp = p;
    for (int n = 0; n < 3 * FRAME && !done; n++) begin
      done = load_valid && !m_pend_full;
      step();
    end
    load_valid = 1'b0;
    checks++;
    if (!done) fail_msg("load_accept_timeout", 0, 1);
  endtask

  task automatic wait_commit();
    for (int n = 0; n < 2 * FRAME && m_pend_full; n++) step();
    checks++;
    if (m_pend_full) fail_msg("commit_timeout", 1, 0);
  endtask

  task automatic clear_counts();
    tick_cnt = 0;
    for (int d = 0; d < 8; d++) lit_cnt[d] = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0)
      fail_msg("reset_outputs", {an, seg, dp, frame_tick}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    checks++;
    if (load_ready !== 1'b1) fail_msg("reset_ready", load_ready, 1);
  endtask

  task automatic test_idle();
    clear_counts();
    for (int n = 0; n < 3 * FRAME; n++) step();
    checks++;
    if (tick_cnt != 3) fail_msg("idle_tick_count", tick_cnt, 3);
  endtask

  task automatic test_count_up();
    do_load(32'h7654_3210, 8'hFF, 8'h00);
    wait_commit();
    clear_counts();
    for (int n = 0; n < FRAME; n++) step();
    checks++;
    if (lit_cnt[0] != DIV - GUARD) fail_msg("lit_cycles_digit0", lit_cnt[0], DIV - GUARD);
    checks++;
    if (lit_cnt[7] != DIV - GUARD) fail_msg("lit_cycles_digit7", lit_cnt[7], DIV - GUARD);
  endtask

  task automatic test_partial_enable();
    do_load(32'hFEDC_BA98, 8'h0F, 8'h05);
    wait_commit();
    clear_counts();
    for (int n = 0; n < FRAME; n++) step();
    checks++;
    if (lit_cnt[2] != DIV - GUARD) fail_msg("lit_cycles_digit2", lit_cnt[2], DIV - GUARD);
    checks++;
    if (lit_cnt[4] != 0) fail_msg("blank_digit4", lit_cnt[4], 0);
  endtask

  task automatic test_back_to_back();
    int accept_k = -1;
    do_load(32'h0000_0011, 8'h01, 8'h00);
    checks++;
    if (load_ready !== 1'b0) fail_msg("ready_low_after_xfer", load_ready, 0);
    load_valid = 1'b1; load_data = 32'h0000_0022; load_en = 8'hFF; load_dp = 8'h80;
    for (int n = 0; n < 3 * FRAME && accept_k < 0; n++) begin
      if (!m_pend_full) accept_k = m_k + 1;
      step();
    end
    load_valid = 1'b0;
    checks++;
    if (accept_k < 0 || (accept_k % FRAME) != 1) fail_msg("second_accept_phase", accept_k % FRAME, 1);
    wait_commit();
    for (int n = 0; n < FRAME + 2; n++) step();
  endtask

  task automatic test_reset_mid();
    int n;
    do_load(32'hABCD_1234, 8'hFF, 8'hFF);
    n = 0;
    while (m_last_an == 8'hFF && n < FRAME) begin step(); n++; end
    checks++;
    if (!m_pend_full) fail_msg("pending_before_reset", 0, 1);
    checks++;
    if (an === 8'hFF) fail_msg("lit_before_reset", an, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0)
      fail_msg("async_reset_outputs", {an, seg, dp, frame_tick}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    checks++;
    if (load_ready !== 1'b1) fail_msg("async_reset_ready", load_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    clear_counts();
    for (int i = 0; i < 2 * FRAME; i++) step();
    checks++;
    if (tick_cnt != 2) fail_msg("post_reset_ticks", tick_cnt, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = $urandom;
      load_en    = 8'($urandom);
      load_dp    = 8'($urandom);
      step();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_idle();
    test_count_up();
    test_partial_enable();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
